// File: rtl/tick_pkg.sv
// Shared constants for the cascaded decade tick generator.
// Holds the default divider shape, the system clock rate and the stage-width helper.
package tick_pkg;

    localparam int BASE_DIV_DEFAULT = 10;
    localparam int STAGES_DEFAULT   = 8;
    localparam int CLK_HZ           = 100_000_000;

    // A stage needs at least one bit, even when the divisor is 2.
    function automatic int count_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mod_n_stage.sv
// One modulo-N counter stage of the tick chain.
// carry_out is combinational so the whole chain wraps in a single cycle.
module mod_n_stage
    import tick_pkg::*;
#(
    parameter int  N = BASE_DIV_DEFAULT,
    localparam int W = count_width(N)
)
(
    input  logic         clock,
    input  logic         clear,
    input  logic         restart,
    input  logic         carry_in,
    output logic [W-1:0] count,
    output logic         carry_out,
    output logic         tick
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;
    logic         tick_reg;
    logic         tick_next;
    logic         wrap;

    // >= rather than == so an out-of-range value can never stick.
    assign wrap = carry_in && (count_reg >= LAST);

    always_comb begin
        count_next = count_reg;
        tick_next  = 1'b0;
        if (restart) begin
            count_next = '0;
        end else if (carry_in) begin
            if (wrap) begin
                count_next = '0;
                tick_next  = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            tick_reg  <= tick_next;
        end
    end

    assign count     = count_reg;
    assign carry_out = wrap;
    assign tick      = tick_reg;

endmodule

// File: rtl/decade_tick_gen.sv
// Cascade of STAGES modulo-BASE_DIV counters producing per-stage wrap ticks,
// the packed digit vector and a square wave of period BASE_DIV**STAGES.
module decade_tick_gen
    import tick_pkg::*;
#(
    parameter int  STAGES   = STAGES_DEFAULT,
    parameter int  BASE_DIV = BASE_DIV_DEFAULT,
    localparam int W        = count_width(BASE_DIV)
)
(
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  restart,
    output logic [STAGES-1:0]     tick,
    output logic [STAGES*W-1:0]   digits,
    output logic                  square_out
);

    localparam logic [W-1:0] HALF = W'(BASE_DIV / 2);

    generate
        if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
            $error("decade_tick_gen: STAGES must be 1..16");
        end
        if (BASE_DIV < 2 || BASE_DIV > 16) begin : g_bad_base
            $error("decade_tick_gen: BASE_DIV must be 2..16");
        end
    endgenerate

    // carry[k] is the carry-in of stage k; carry[STAGES] is the top wrap.
    logic [STAGES:0] carry;
    assign carry[0] = enable;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            mod_n_stage #(
                .N (BASE_DIV)
            ) u_stage (
                .clock     (clock),
                .clear     (clear),
                .restart   (restart),
                .carry_in  (carry[gi]),
                .count     (digits[gi*W +: W]),
                .carry_out (carry[gi+1]),
                .tick      (tick[gi])
            );
        end
    endgenerate

    logic [W-1:0] top_count;
    logic [W-1:0] top_next;
    logic         square_reg;
    logic         square_next;

    assign top_count = digits[(STAGES-1)*W +: W];

    // Square wave tracks the top digit's value after this edge, not before it.
    always_comb begin
        top_next = top_count;
        if (carry[STAGES-1]) begin
            top_next = carry[STAGES] ? '0 : top_count + 1'b1;
        end
        square_next = !restart && (top_next >= HALF);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            square_reg <= 1'b0;
        end else begin
            square_reg <= square_next;
        end
    end

    assign square_out = square_reg;

endmodule
